// File: rtl/gps_pkg.sv
// Shared constants for the carrier NCO: widths and the 8-entry carrier LUT.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   GPS_PHASE_W / GPS_CNT_W : default accumulator and cycle counter widths
//   AMP_W                   : carrier amplitude width (signed)
//   COS_LUT / SIN_LUT       : packed tables, entry k at bits [k*AMP_W +: AMP_W]
package gps_pkg;

  localparam int GPS_PHASE_W = 32;
  localparam int GPS_CNT_W   = 32;
  localparam int AMP_W       = 3;
  localparam int LUT_N       = 8;

  typedef logic signed [AMP_W-1:0] amp_t;

  // Entries listed k=7 down to k=0.
  // cos k=0..7 : +2 +2 +1 -1 -2 -2 -1 +1
  localparam logic [LUT_N*AMP_W-1:0] COS_LUT = {
    3'b001, 3'b111, 3'b110, 3'b110, 3'b111, 3'b001, 3'b010, 3'b010
  };
  // sin k=0..7 : +1 +2 +2 +1 -1 -2 -2 -1
  localparam logic [LUT_N*AMP_W-1:0] SIN_LUT = {
    3'b111, 3'b110, 3'b110, 3'b111, 3'b001, 3'b010, 3'b010, 3'b001
  };

  // LUT[0] values, used as reset/clear state of the registered outputs.
  localparam amp_t COS_K0 = COS_LUT[AMP_W-1:0];
  localparam amp_t SIN_K0 = SIN_LUT[AMP_W-1:0];

endpackage

// File: rtl/carrier_lut.sv
// Combinational 3-bit phase-to-carrier lookup (cos/sin, 8 phase sectors).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   k       in  3      phase sector index (top bits of the accumulator)
//   cos_val out AMP_W  signed cosine sample
//   sin_val out AMP_W  signed sine sample
module carrier_lut
  import gps_pkg::*;
(
  input  logic [2:0] k,
  output amp_t       cos_val,
  output amp_t       sin_val
);

  always_comb begin
    cos_val = COS_LUT[k*AMP_W +: AMP_W];
    sin_val = SIN_LUT[k*AMP_W +: AMP_W];
  end

endmodule

// File: rtl/carrier_nco.sv
// Carrier NCO: phase accumulator with loop correction, carrier cycle counter,
// epoch latch and 3-bit cos/sin output.
// Latency: phase/cos/sin update on the sample_en edge; correction takes effect
// two edges after its strobe; epoch latch result visible the next cycle.
// Backpressure: none; sample_en simply gates the accumulator.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sample_en           advance phase by freq_eff
//   freq_nominal        unsigned nominal frequency word
//   correction          signed correction word, qualified by corr_valid
//   epoch               latch running cycle count and phase
//   clear               synchronous clear (priority over everything else)
//   cos_out, sin_out    registered carrier samples
//   phase_out           accumulator phase
//   cycle_count         running cycle count latched at last epoch
//   phase_latch         phase latched at last epoch
//   cycle_valid         one-cycle pulse after an accepted epoch
module carrier_nco
  import gps_pkg::*;
#(
  parameter int PHASE_W = GPS_PHASE_W,
  parameter int CNT_W   = GPS_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_en,
  input  logic [PHASE_W-1:0] freq_nominal,
  input  logic [PHASE_W-1:0] correction,
  input  logic               corr_valid,
  input  logic               epoch,
  input  logic               clear,
  output logic [AMP_W-1:0]   cos_out,
  output logic [AMP_W-1:0]   sin_out,
  output logic [PHASE_W-1:0] phase_out,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [PHASE_W-1:0] phase_latch,
  output logic               cycle_valid
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] corr_q, corr_d;
  logic [PHASE_W-1:0] freq_eff_q, freq_eff_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
  logic [PHASE_W-1:0] phase_latch_q, phase_latch_d;
  logic               cycle_valid_q, cycle_valid_d;
  amp_t               cos_q, cos_d;
  amp_t               sin_q, sin_d;

  logic [PHASE_W:0]   sum;
  logic               carry;

  // Extra MSB of the sum is the carry that marks one full carrier cycle.
  assign sum   = {1'b0, phase_q} + {1'b0, freq_eff_q};
  assign carry = sum[PHASE_W];

  always_comb begin
    phase_d       = phase_q;
    corr_d        = corr_q;
    cnt_d         = cnt_q;
    cycle_count_d = cycle_count_q;
    phase_latch_d = phase_latch_q;
    cycle_valid_d = 1'b0;
    // Correction term enters through corr_q, so a new correction is seen by
    // freq_eff one edge after capture and by the accumulator one edge later.
    freq_eff_d    = freq_nominal + corr_q;

    if (clear) begin
      phase_d    = '0;
      corr_d     = '0;
      cnt_d      = '0;
      freq_eff_d = freq_nominal;
    end else begin
      if (corr_valid) begin
        corr_d = correction;
      end
      if (sample_en) begin
        phase_d = sum[PHASE_W-1:0];
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, carry};
      end
      // Epoch captures the post-update values, including this edge's carry.
      if (epoch) begin
        cycle_count_d = cnt_d;
        phase_latch_d = phase_d;
        cycle_valid_d = 1'b1;
      end
    end
  end

  // Outputs follow the next phase so they change on the same edge as phase_q.
  carrier_lut u_lut (
    .k       (phase_d[PHASE_W-1 -: 3]),
    .cos_val (cos_d),
    .sin_val (sin_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= '0;
      corr_q        <= '0;
      freq_eff_q    <= '0;
      cnt_q         <= '0;
      cycle_count_q <= '0;
      phase_latch_q <= '0;
      cycle_valid_q <= 1'b0;
      cos_q         <= COS_K0;
      sin_q         <= SIN_K0;
    end else begin
      phase_q       <= phase_d;
      corr_q        <= corr_d;
      freq_eff_q    <= freq_eff_d;
      cnt_q         <= cnt_d;
      cycle_count_q <= cycle_count_d;
      phase_latch_q <= phase_latch_d;
      cycle_valid_q <= cycle_valid_d;
      cos_q         <= cos_d;
      sin_q         <= sin_d;
    end
  end

  assign phase_out   = phase_q;
  assign cycle_count = cycle_count_q;
  assign phase_latch = phase_latch_q;
  assign cycle_valid = cycle_valid_q;
  assign cos_out     = cos_q;
  assign sin_out     = sin_q;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed bench for carrier_nco: reset, stepping, correction timing, wrap,
// epoch on carry, clear versus epoch.
module tb_carrier_nco;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic [31:0] freq_nominal;
  logic [31:0] correction;
  logic        corr_valid;
  logic        epoch;
  logic        clear;
  logic [2:0]  cos_out;
  logic [2:0]  sin_out;
  logic [31:0] phase_out;
  logic [31:0] cycle_count;
  logic [31:0] phase_latch;
  logic        cycle_valid;

  int n_chk = 0;
  int n_err = 0;

  // Hand-written carrier table, k = 0..7.
  logic [2:0] exp_cos [8] = '{3'b010, 3'b010, 3'b001, 3'b111,
                              3'b110, 3'b110, 3'b111, 3'b001};
  logic [2:0] exp_sin [8] = '{3'b001, 3'b010, 3'b010, 3'b001,
                              3'b111, 3'b110, 3'b110, 3'b111};

  carrier_nco #(.PHASE_W(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_en    (sample_en),
    .freq_nominal (freq_nominal),
    .correction   (correction),
    .corr_valid   (corr_valid),
    .epoch        (epoch),
    .clear        (clear),
    .cos_out      (cos_out),
    .sin_out      (sin_out),
    .phase_out    (phase_out),
    .cycle_count  (cycle_count),
    .phase_latch  (phase_latch),
    .cycle_valid  (cycle_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cs(input string tag, input int k);
    chk({tag, "_cos"}, {29'd0, cos_out}, {29'd0, exp_cos[k]});
    chk({tag, "_sin"}, {29'd0, sin_out}, {29'd0, exp_sin[k]});
  endtask

  initial begin
    rst          = 1'b1;
    sample_en    = 1'b0;
    freq_nominal = 32'h2000_0000;
    correction   = 32'h0;
    corr_valid   = 1'b0;
    epoch        = 1'b0;
    clear        = 1'b0;
    step();
    step();
    chk("rst_phase", phase_out, 32'h0);
    chk_cs("rst", 0);
    chk("rst_cnt", cycle_count, 32'h0);
    chk("rst_latch", phase_latch, 32'h0);
    chk("rst_vld", {31'd0, cycle_valid}, 32'h0);

    // Stepping at 1/8 cycle per sample; epoch on the 8th (wrapping) sample.
    rst = 1'b0;
    step();
    sample_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) epoch = 1'b1;
      step();
      epoch = 1'b0;
      chk("step_phase", phase_out, 32'(i) * 32'h2000_0000);
      chk_cs("step", i % 8);
    end
    chk("step_cnt", cycle_count, 32'd1);
    chk("step_latch", phase_latch, 32'h0);
    chk("step_vld", {31'd0, cycle_valid}, 32'h1);
    sample_en = 1'b0;
    step();
    chk("step_vld_drop", {31'd0, cycle_valid}, 32'h0);
    chk("step_hold", phase_out, 32'h0);

    // Asynchronous reset mid-stream.
    sample_en = 1'b1;
    step();
    step();
    step();
    chk("pre_rst_phase", phase_out, 32'h6000_0000);
    #2 rst = 1'b1;
    #1;
    chk("arst_phase", phase_out, 32'h0);
    chk_cs("arst", 0);
    chk("arst_cnt", cycle_count, 32'h0);
    chk("arst_vld", {31'd0, cycle_valid}, 32'h0);
    sample_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    sample_en = 1'b1;
    step();
    chk("post_rst_phase", phase_out, 32'h2000_0000);
    sample_en = 1'b0;

    // Correction: applies two edges after the strobe.
    freq_nominal = 32'h1000_0000;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_phase", phase_out, 32'h0);
    chk_cs("clr", 0);
    sample_en  = 1'b1;
    corr_valid = 1'b1;
    correction = 32'h1000_0000;
    step();
    corr_valid = 1'b0;
    chk("corr_n", phase_out, 32'h1000_0000);
    step();
    chk("corr_n1", phase_out, 32'h2000_0000);
    step();
    chk("corr_n2", phase_out, 32'h4000_0000);
    step();
    chk("corr_n3", phase_out, 32'h6000_0000);
    corr_valid = 1'b1;
    correction = 32'hF000_0000;
    step();
    corr_valid = 1'b0;
    chk("neg_n", phase_out, 32'h8000_0000);
    step();
    chk("neg_n1", phase_out, 32'hA000_0000);
    step();
    chk("neg_n2", phase_out, 32'hA000_0000);
    step();
    chk("neg_n3", phase_out, 32'hA000_0000);
    chk_cs("neg", 5);

    // Frequency word wrap: 0xFFFFFFFF + 2 = 1.
    sample_en    = 1'b0;
    freq_nominal = 32'hFFFF_FFFF;
    corr_valid   = 1'b1;
    correction   = 32'h0000_0002;
    step();
    corr_valid = 1'b0;
    step();
    sample_en = 1'b1;
    step();
    chk("wrap_1", phase_out, 32'hA000_0001);
    step();
    chk("wrap_2", phase_out, 32'hA000_0002);
    step();
    chk("wrap_3", phase_out, 32'hA000_0003);
    sample_en = 1'b0;

    // Epoch on the carry edge.
    freq_nominal = 32'h2000_0000;
    clear = 1'b1;
    step();
    clear = 1'b0;
    sample_en = 1'b1;
    repeat (7) step();
    chk("ec_pre", phase_out, 32'hE000_0000);
    sample_en    = 1'b0;
    freq_nominal = 32'h4000_0000;
    step();
    sample_en = 1'b1;
    epoch     = 1'b1;
    step();
    sample_en = 1'b0;
    epoch     = 1'b0;
    chk("ec_phase", phase_out, 32'h2000_0000);
    chk("ec_cnt", cycle_count, 32'd1);
    chk("ec_latch", phase_latch, 32'h2000_0000);
    chk("ec_vld", {31'd0, cycle_valid}, 32'h1);
    chk_cs("ec", 1);
    step();
    chk("ec_vld_drop", {31'd0, cycle_valid}, 32'h0);
    chk("ec_cnt_hold", cycle_count, 32'd1);

    // Clear beats a simultaneous epoch; next epoch shows the zeroed counter.
    clear     = 1'b1;
    epoch     = 1'b1;
    sample_en = 1'b1;
    step();
    clear     = 1'b0;
    sample_en = 1'b0;
    chk("ce_phase", phase_out, 32'h0);
    chk("ce_vld", {31'd0, cycle_valid}, 32'h0);
    chk("ce_cnt", cycle_count, 32'd1);
    chk("ce_latch", phase_latch, 32'h2000_0000);
    chk_cs("ce", 0);
    step();
    epoch = 1'b0;
    chk("ce2_cnt", cycle_count, 32'd0);
    chk("ce2_latch", phase_latch, 32'h0);
    chk("ce2_vld", {31'd0, cycle_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/carrier_nco.md
CARRIER_NCO -- requirements
Module: carrier_nco

Interface
REQ-001 Parameter: PHASE_W, 32, phase accumulator, frequency word and correction width.
REQ-002 Parameter: CNT_W, 32, carrier cycle counter width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 sample_en  in  1  advance phase by one sample when high.
REQ-006 freq_nominal  in  PHASE_W  unsigned nominal carrier frequency word (IF + Doppler estimate).
REQ-007 correction  in  PHASE_W  signed loop-filter correction word.
REQ-008 corr_valid  in  1  one-cycle strobe qualifying correction.
REQ-009 epoch  in  1  latch request for the cycle count and phase (code epoch / dump).
REQ-010 clear  in  1  synchronous clear of accumulator, counter and correction.
REQ-011 cos_out  out  3  signed carrier cosine sample.
REQ-012 sin_out  out  3  signed carrier sine sample.
REQ-013 phase_out  out  PHASE_W  current accumulator phase.
REQ-014 cycle_count  out  CNT_W  running carrier cycle count latched at the last epoch.
REQ-015 phase_latch  out  PHASE_W  accumulator phase latched at the last epoch.
REQ-016 cycle_valid  out  1  one-cycle pulse marking new cycle_count/phase_latch.

Function
REQ-017 On the edge where corr_valid is high, corr_reg SHALL capture correction; corr_reg holds otherwise.
REQ-018 freq_eff SHALL be registered as freq_nominal + corr_reg, modulo 2^PHASE_W, updated every cycle; a correction strobed at edge N governs increments from edge N+2.
REQ-019 On an edge with sample_en high, phase SHALL become phase + freq_eff modulo 2^PHASE_W; without sample_en, phase holds.
REQ-020 Carry out of that addition SHALL increment the running cycle counter by 1, modulo 2^CNT_W; no carry means no increment.
REQ-021 cos_out/sin_out SHALL be registered from the top 3 bits (k) of the next phase value, changing on the same edge as phase.
REQ-022 LUT for k=0..7: cos = +2,+2,+1,-1,-2,-2,-1,+1; sin = +1,+2,+2,+1,-1,-2,-2,-1.
REQ-023 On an edge with epoch high, cycle_count and phase_latch SHALL capture the post-update running count and phase, including a carry or increment on that same edge, and cycle_valid SHALL be high for exactly the following cycle.
REQ-024 epoch does not reset the running counter; the count is continuous across epochs.
REQ-025 clear SHALL zero phase, the running counter, corr_reg and freq_eff's correction term, and SHALL set cos_out/sin_out to LUT[0].
REQ-026 clear has priority over sample_en, corr_valid and epoch; a simultaneous epoch is dropped (no cycle_valid); cycle_count and phase_latch hold.
REQ-027 corr_valid and sample_en on the same edge: the increment SHALL use the old freq_eff.

Reset
REQ-028 While rst is high, phase, the running counter, corr_reg, freq_eff, cycle_count, phase_latch and cycle_valid SHALL be 0, with cos_out=+2 and sin_out=+1.
REQ-029 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge; the first sample_en after release starts from phase 0.

Structure
REQ-030 gps_pkg SHALL hold PHASE_W, CNT_W, the carrier amplitude width (3) and the 8-entry cos/sin LUT constants.
REQ-031 A combinational sub-module carrier_lut (3-bit index in, cos/sin out) SHALL implement REQ-022.

Verification
REQ-032 Reset: run at freq 0x2000_0000, then pulse rst mid-stream -> phase_out=0, cos=+2, sin=+1, cycle_count=0, cycle_valid=0.
REQ-033 Stepping: freq_nominal=0x2000_0000, continuous sample_en -> phase 0x2000_0000, 0x4000_0000, ... with k=1..7,0; after 8 samples phase=0, running count=1.
REQ-034 Correction: nominal 0x1000_0000, corr_valid with 0x1000_0000 -> steps 0x2000_0000 from edge N+2; then correction 0xF000_0000 (-0x1000_0000) -> step 0, phase frozen.
REQ-035 Wrap: nominal 0xFFFF_FFFF, correction +2 -> freq_eff 0x0000_0001; phase steps by 1.
REQ-036 Epoch on carry: phase 0xE000_0000, freq 0x4000_0000, sample_en and epoch on the same edge -> cycle_count = old+1, phase_latch=0x2000_0000, cycle_valid high one cycle.
REQ-037 clear with epoch on the same edge -> phase=0, counter=0, no cycle_valid; prior cycle_count unchanged.
